// File: rtl/onehot_decoder_seq.sv
// One-hot decoder with a handshake-driven decode mode and a timed scan mode.
// Outputs are registered; sel_ready is a combinational view of state, en and mode.
module onehot_decoder_seq #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8,
    localparam int OUT_W  = 2 ** SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               sel_valid,
    input  logic [SEL_W-1:0]   sel,
    output logic               sel_ready,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   out,
    output logic               out_valid,
    output logic               wrap
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0]   IDX_ZERO = SEL_W'(0);
    localparam logic [SEL_W-1:0]   IDX_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0]   IDX_LAST = SEL_W'(OUT_W - 1);
    localparam logic [DWELL_W-1:0] CNT_ZERO = DWELL_W'(0);
    localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);
    localparam logic [OUT_W-1:0]   OUT_ZERO = {OUT_W{1'b0}};
    localparam logic [OUT_W-1:0]   OUT_BIT0 = OUT_W'(1);

    function automatic logic [OUT_W-1:0] onehot_f(input logic [SEL_W-1:0] idx);
        onehot_f = OUT_BIT0 << idx;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [OUT_W-1:0]   out_r;
    logic [OUT_W-1:0]   out_nxt_s;
    logic               out_valid_r;
    logic               wrap_r;
    logic               wrap_nxt_s;
    logic [DWELL_W-1:0] cnt_r;
    logic [DWELL_W-1:0] cnt_nxt_s;
    logic [SEL_W-1:0]   idx_r;
    logic [SEL_W-1:0]   idx_nxt_s;
    logic [SEL_W-1:0]   idx_inc_s;
    logic               accept_state_s;

    // Index increment wraps naturally at OUT_W because idx_r is SEL_W wide.
    assign idx_inc_s      = idx_r + IDX_ONE;
    assign accept_state_s = (state_r == ST_IDLE) || (state_r == ST_DECODE);
    // rst_n gates readiness so nothing is offered while the block is held in reset.
    assign sel_ready      = rst_n & en & ~mode & accept_state_s;

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign wrap      = wrap_r;

    // Next-state and next-output logic for decode/scan sequencing.
    always_comb begin
        state_nxt_s = state_r;
        out_nxt_s   = out_r;
        wrap_nxt_s  = 1'b0;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        if (!en) begin
            state_nxt_s = ST_IDLE;
            out_nxt_s   = OUT_ZERO;
            cnt_nxt_s   = CNT_ZERO;
            idx_nxt_s   = IDX_ZERO;
        end else begin
            case (state_r)
                ST_IDLE, ST_DECODE: begin
                    // Scan request wins over a simultaneous sel_valid (sel_ready is low).
                    if (mode) begin
                        state_nxt_s = ST_SCAN;
                        out_nxt_s   = OUT_BIT0;
                        cnt_nxt_s   = dwell;
                        idx_nxt_s   = IDX_ZERO;
                    end else if (sel_valid) begin
                        state_nxt_s = ST_DECODE;
                        out_nxt_s   = onehot_f(sel);
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_SCAN: begin
                    if (!mode) begin
                        state_nxt_s = ST_IDLE;
                        out_nxt_s   = OUT_ZERO;
                        cnt_nxt_s   = CNT_ZERO;
                        idx_nxt_s   = IDX_ZERO;
                    end else if (cnt_r == CNT_ZERO) begin
                        idx_nxt_s   = idx_inc_s;
                        out_nxt_s   = onehot_f(idx_inc_s);
                        cnt_nxt_s   = dwell;
                        wrap_nxt_s  = (idx_r == IDX_LAST);
                    end else begin
                        cnt_nxt_s   = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    out_nxt_s   = OUT_ZERO;
                    cnt_nxt_s   = CNT_ZERO;
                    idx_nxt_s   = IDX_ZERO;
                end
            endcase
        end
    end

    // State and registered output update; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_r       <= OUT_ZERO;
            out_valid_r <= 1'b0;
            wrap_r      <= 1'b0;
            cnt_r       <= CNT_ZERO;
            idx_r       <= IDX_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            out_r       <= out_nxt_s;
            out_valid_r <= |out_nxt_s;
            wrap_r      <= wrap_nxt_s;
            cnt_r       <= cnt_nxt_s;
            idx_r       <= idx_nxt_s;
        end
    end

    onehot_decoder_seq_chk #(
        .OUT_W (OUT_W)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .out       (out_r),
        .out_valid (out_valid_r),
        .wrap      (wrap_r)
    );

endmodule

// Output invariants: at most one bit set, valid tracks non-zero, wrap only with bit 0.
module onehot_decoder_seq_chk #(
    parameter int OUT_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    input logic [OUT_W-1:0] out,
    input logic             out_valid,
    input logic             wrap
);

    a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(out));
    a_valid : assert property (@(posedge clk) disable iff (!rst_n)
        out_valid == (out != {OUT_W{1'b0}}));
    a_wrap : assert property (@(posedge clk) disable iff (!rst_n)
        wrap |-> out[0]);

endmodule

// File: doc/onehot_decoder_seq.md
ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

Parameters
REQ-001 SEL_W, default 3, select width; OUT_W = 2**SEL_W is derived and is not a parameter.
REQ-002 DWELL_W, default 8, width of the scan dwell count.

Interface
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  block enable; 0 forces idle.
REQ-006 mode  input  1  0 = decode mode, 1 = scan mode.
REQ-007 sel_valid  input  1  sel is offered this cycle.
REQ-008 sel  input  SEL_W  index to decode.
REQ-009 sel_ready  output  1  block accepts sel this cycle; combinational from state, en and mode only.
REQ-010 dwell  input  DWELL_W  scan hold count; each scan step lasts dwell+1 cycles.
REQ-011 out  output  OUT_W  registered one-hot output, or all-zero.
REQ-012 out_valid  output  1  out holds a valid one-hot value.
REQ-013 wrap  output  1  one-cycle pulse when a scan returns to index 0 after index OUT_W-1.

Function
REQ-014 States SHALL be IDLE, DECODE and SCAN.
REQ-015 out SHALL be all-zero or exactly one bit set; never more than one bit set.
REQ-016 out_valid SHALL be 1 exactly when out is non-zero.
REQ-017 en=0 overrides all other inputs: next state IDLE; out=0, out_valid=0, wrap=0.
REQ-018 sel_ready SHALL be 1 only when en=1, mode=0 and state is IDLE or DECODE.
REQ-019 Transfer occurs when sel_valid and sel_ready are both 1; the next edge sets out = 1<<sel, out_valid=1, state DECODE (latency 1 cycle).
REQ-020 In DECODE with no transfer, out SHALL hold its value indefinitely.
REQ-021 sel_valid while sel_ready=0 SHALL be ignored; nothing is queued.
REQ-022 IDLE or DECODE with en=1, mode=1: next edge enters SCAN with out bit 0 set, out_valid=1, and dwell counter loaded from dwell.
REQ-023 In SCAN the counter decrements each cycle; at 0, the next edge advances out to the next bit index and reloads the counter from the current dwell.
REQ-024 dwell SHALL be sampled only at step load; mid-step changes do not affect the current step.
REQ-025 dwell=0 SHALL advance every cycle.
REQ-026 Advance from index OUT_W-1 SHALL wrap to index 0 and assert wrap for that one cycle, coincident with bit 0 reasserting; initial scan entry SHALL NOT assert wrap.
REQ-027 mode 1->0 while in SCAN: next edge goes to IDLE with out=0, out_valid=0; sel_ready rises in the cycle after that edge.
REQ-028 mode 0->1 in DECODE: a simultaneous sel_valid is not accepted (sel_ready=0), and scan starts at index 0 per REQ-022.
REQ-029 Index arithmetic SHALL be modulo OUT_W; sel is always in range by construction.

Reset
REQ-030 While rst_n=0: state IDLE; out=0, out_valid=0, wrap=0, dwell counter 0, scan index 0; sel_ready=0 regardless of inputs.
REQ-031 Reset assertion SHALL take effect immediately, mid-scan or mid-decode, without waiting for clk.
REQ-032 After deassertion, the first edge with en=1 behaves as from IDLE.

Verification
REQ-033 SEL_W=3, en=1, mode=0, sel=5 with sel_valid for 1 cycle -> next cycle out=8'b00100000, out_valid=1, held until the next transfer.
REQ-034 Exhaustive decode sweep, all sel values for SEL_W=3 and SEL_W=4 -> out = 1<<sel every time; one-hot check holds on every cycle.
REQ-035 mode=1, dwell=2, SEL_W=3 -> each bit is held 3 cycles; after 24 cycles bit 0 returns with wrap=1 for exactly 1 cycle.
REQ-036 Scan with dwell=0 -> out advances every cycle; wrap fires every 8 cycles.
REQ-037 Mid-scan at index 4: mode->0 -> next cycle out=0, sel_ready=1; sel=2 accepted -> out=8'b00000100.
REQ-038 rst_n pulsed low between edges mid-scan -> out=0 and out_valid=0 immediately; en=0 at any point -> out=0 on the next edge.
